// File: rtl/kb_event_decoder_pkg.sv
// Shared constants, state encoding and event record for the PS/2 set-2 event decoder.
package kb_event_decoder_pkg;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  // Keyboard housekeeping replies that never form part of a key event
  localparam logic [7:0] CODE_ACK    = 8'hFA;
  localparam logic [7:0] CODE_BAT_OK = 8'hAA;
  localparam logic [7:0] CODE_ECHO   = 8'hEE;
  localparam logic [7:0] CODE_RESEND = 8'hFE;

  localparam logic [7:0] CODE_CAPS   = 8'h58;
  localparam logic [7:0] CODE_NUM    = 8'h77;
  localparam logic [7:0] CODE_SCROLL = 8'h7E;

  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CTRL   = 8'h14;
  localparam logic [7:0] CODE_ALT    = 8'h11;

  localparam int LOCK_CAPS   = 0;
  localparam int LOCK_NUM    = 1;
  localparam int LOCK_SCROLL = 2;

  localparam int MOD_LSHIFT = 0;
  localparam int MOD_RSHIFT = 1;
  localparam int MOD_CTRL   = 2;
  localparam int MOD_ALT    = 3;

  localparam int EVENT_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } event_t;

  function automatic logic is_discard(input logic [7:0] b);
    return (b == CODE_ACK) || (b == CODE_BAT_OK) || (b == CODE_ECHO) || (b == CODE_RESEND);
  endfunction

endpackage

// File: rtl/kb_event_decoder_fifo.sv
// First-word-fall-through event FIFO; a push on a full FIFO is accepted only
// when a pop frees a slot in the same cycle, otherwise it is dropped and flagged.
module kb_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign data_out = empty ? '0 : mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow
  always_ff @(posedge clk) begin
    if (sclr) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_push) overflow <= 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!sclr && do_push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/kb_event_decoder.sv
// PS/2 set-2 scancode decoder: prefix FSM, lock toggles with typematic
// suppression, live modifier levels and a FWFT queue of completed events.
module kb_event_decoder
  import kb_event_decoder_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [2:0] LOCK_INIT  = 3'b000
) (
  input  logic       clk,
  input  logic       i_sclr,
  input  logic       i_byte_en,
  input  logic [7:0] i_byte,
  input  logic       i_pop,
  output logic       o_valid,
  output logic [7:0] o_code,
  output logic       o_ext,
  output logic       o_break,
  output logic       o_full,
  output logic       o_overflow,
  output logic [2:0] o_locks,
  output logic [3:0] o_mods
);

  state_t     state;
  state_t     state_nxt;
  logic       emit;
  event_t     ev;
  event_t     head;
  logic       empty;
  logic [2:0] locks_q, locks_nxt;
  logic [2:0] held_q, held_nxt;
  logic [3:0] mods_q, mods_nxt;
  logic [2:0] lock_hit;
  logic [3:0] mod_hit;

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      state   <= ST_IDLE;
      locks_q <= LOCK_INIT;
      held_q  <= '0;
      mods_q  <= '0;
    end else begin
      state   <= state_nxt;
      locks_q <= locks_nxt;
      held_q  <= held_nxt;
      mods_q  <= mods_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    ev        = '0;
    ev.code   = i_byte;
    if (i_byte_en) begin
      case (state)
        ST_IDLE: begin
          if (i_byte == PREFIX_EXT)      state_nxt = ST_EXT;
          else if (i_byte == PREFIX_BRK) state_nxt = ST_BRK;
          else if (!is_discard(i_byte))  emit = 1'b1;
        end
        ST_EXT: begin
          if (i_byte == PREFIX_BRK) begin
            state_nxt = ST_EXT_BRK;
          end else if (i_byte != PREFIX_EXT) begin
            emit      = 1'b1;
            ev.ext    = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          emit      = 1'b1;
          ev.brk    = 1'b1;
          state_nxt = ST_IDLE;
        end
        ST_EXT_BRK: begin
          emit      = 1'b1;
          ev.ext    = 1'b1;
          ev.brk    = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Lock keys only exist as non-extended codes; ctrl/alt accept either form
  always_comb begin
    lock_hit              = '0;
    lock_hit[LOCK_CAPS]   = emit && !ev.ext && (ev.code == CODE_CAPS);
    lock_hit[LOCK_NUM]    = emit && !ev.ext && (ev.code == CODE_NUM);
    lock_hit[LOCK_SCROLL] = emit && !ev.ext && (ev.code == CODE_SCROLL);

    mod_hit             = '0;
    mod_hit[MOD_LSHIFT] = emit && !ev.ext && (ev.code == CODE_LSHIFT);
    mod_hit[MOD_RSHIFT] = emit && !ev.ext && (ev.code == CODE_RSHIFT);
    mod_hit[MOD_CTRL]   = emit && (ev.code == CODE_CTRL);
    mod_hit[MOD_ALT]    = emit && (ev.code == CODE_ALT);

    locks_nxt = locks_q;
    held_nxt  = held_q;
    mods_nxt  = mods_q;
    for (int i = 0; i < 3; i++) begin
      if (lock_hit[i]) begin
        if (ev.brk) begin
          held_nxt[i] = 1'b0;
        end else if (!held_q[i]) begin
          locks_nxt[i] = ~locks_q[i];
          held_nxt[i]  = 1'b1;
        end
      end
    end
    for (int j = 0; j < 4; j++) begin
      if (mod_hit[j]) mods_nxt[j] = !ev.brk;
    end
  end

  kb_event_fifo #(
    .WIDTH(EVENT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .sclr     (i_sclr),
    .push     (emit),
    .data_in  (ev),
    .pop      (i_pop),
    .data_out (head),
    .empty    (empty),
    .full     (o_full),
    .overflow (o_overflow)
  );

  assign o_valid = !empty;
  assign o_code  = head.code;
  assign o_ext   = head.ext;
  assign o_break = head.brk;
  assign o_locks = locks_q;
  assign o_mods  = mods_q;

endmodule

// File: tb/tb_kb_event_decoder.sv
// Randomised bench for kb_event_decoder with a prefix/lock/modifier model and
// an expected-event queue checked by a negedge monitor.
module tb_kb_event_decoder;

  localparam int         DEPTH     = 4;
  localparam logic [2:0] LOCK_INIT = 3'b010;

  logic       clk;
  logic       i_sclr;
  logic       i_byte_en;
  logic [7:0] i_byte;
  logic       i_pop;
  logic       o_valid;
  logic [7:0] o_code;
  logic       o_ext;
  logic       o_break;
  logic       o_full;
  logic       o_overflow;
  logic [2:0] o_locks;
  logic [3:0] o_mods;

  kb_event_decoder #(
    .FIFO_DEPTH(DEPTH),
    .LOCK_INIT (LOCK_INIT)
  ) dut (
    .clk       (clk),
    .i_sclr    (i_sclr),
    .i_byte_en (i_byte_en),
    .i_byte    (i_byte),
    .i_pop     (i_pop),
    .o_valid   (o_valid),
    .o_code    (o_code),
    .o_ext     (o_ext),
    .o_break   (o_break),
    .o_full    (o_full),
    .o_overflow(o_overflow),
    .o_locks   (o_locks),
    .o_mods    (o_mods)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [9:0] exp_q[$];
  bit         m_ext, m_brk;
  bit         m_ovf;
  logic [2:0] m_locks;
  bit         m_held[3];
  logic [3:0] m_mods;
  bit         check_en;
  int         n_checks;
  int         n_fail;

  function automatic void model_reset();
    exp_q.delete();
    m_ext = 0; m_brk = 0; m_ovf = 0;
    m_locks = LOCK_INIT;
    m_mods = 4'b0000;
    for (int i = 0; i < 3; i++) m_held[i] = 0;
  endfunction

  function automatic void model_event(input bit ext, input bit brk, input logic [7:0] code);
    logic [7:0] lock_codes[3];
    lock_codes[0] = 8'h58; lock_codes[1] = 8'h77; lock_codes[2] = 8'h7E;
    m_ext = 0; m_brk = 0;
    for (int i = 0; i < 3; i++) begin
      if (!ext && code == lock_codes[i]) begin
        if (brk) m_held[i] = 0;
        else if (!m_held[i]) begin
          m_locks[i] = ~m_locks[i];
          m_held[i] = 1;
        end
      end
    end
    if (!ext && code == 8'h12) m_mods[0] = !brk;
    if (!ext && code == 8'h59) m_mods[1] = !brk;
    if (code == 8'h14) m_mods[2] = !brk;
    if (code == 8'h11) m_mods[3] = !brk;
    // the monitor has already retired any popped head, so room means accepted
    if (exp_q.size() < DEPTH) exp_q.push_back({ext, brk, code});
    else m_ovf = 1;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (m_brk) model_event(m_ext, 1, b);
    else if (m_ext) begin
      if (b == 8'hF0) m_brk = 1;
      else if (b != 8'hE0) model_event(1, 0, b);
    end else begin
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (!(b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE})) model_event(0, 0, b);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit en, input logic [7:0] b, input bit p);
    i_byte_en = en;
    i_byte    = b;
    i_pop     = p;
    @(posedge clk);
    if (en) model_byte(b);
    #1;
    i_byte_en = 1'b0;
    i_pop     = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b, 1'b0);
  endtask

  task automatic do_reset();
    i_sclr    = 1'b1;
    i_byte_en = 1'b0;
    i_pop     = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    i_sclr   = 1'b0;
    check_en = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * DEPTH + 2; k++) cyc(1'b0, 8'h00, 1'b1);
  endtask

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 15))
      0, 1:    return 8'hE0;
      2, 3:    return 8'hF0;
      4:       return 8'h58;
      5:       return 8'h77;
      6:       return 8'h7E;
      7:       return 8'h12;
      8:       return 8'h59;
      9:       return 8'h14;
      10:      return 8'h11;
      11:      return 8'hAA;
      12:      return 8'hFA;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("valid",    32'(o_valid),    32'(exp_q.size() != 0));
      check("full",     32'(o_full),     32'(exp_q.size() == DEPTH));
      check("overflow", 32'(o_overflow), 32'(m_ovf));
      check("locks",    32'(o_locks),    32'(m_locks));
      check("mods",     32'(o_mods),     32'(m_mods));
      if (exp_q.size() != 0) check("head", 32'({o_ext, o_break, o_code}), 32'(exp_q[0]));
      else                   check("head_empty", 32'({o_ext, o_break, o_code}), 32'd0);
      if (i_pop && !i_sclr && exp_q.size() != 0) void'(exp_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    check_en  = 1'b0;
    i_sclr    = 1'b1;
    i_byte_en = 1'b0;
    i_byte    = 8'h00;
    i_pop     = 1'b0;
    model_reset();
    do_reset();
    cyc(1'b0, 8'h00, 1'b0);

    // make/break and extended sequences
    send(8'h1C); send(8'hF0); send(8'h1C);
    drain();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    drain();

    // caps with typematic repeats, then a second press
    send(8'h58); send(8'h58); send(8'h58); drain();
    send(8'hF0); send(8'h58); send(8'h58); drain();

    // modifier levels
    send(8'h12); send(8'hE0); send(8'h11); drain();
    send(8'hF0); send(8'h12); send(8'hE0); send(8'hF0); send(8'h11); drain();

    // fill, drop one, then push with pop while full
    for (int i = 0; i < 5; i++) send(8'h20 + 8'(i));
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'h30, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    drain();

    // reset mid-sequence, and a discarded byte in IDLE
    do_reset();
    send(8'hE0);
    do_reset();
    send(8'h1C); send(8'hAA); send(8'hE0); send(8'hE0); send(8'h6B);
    drain();

    // randomised traffic with varying pop pressure
    for (int phase = 0; phase < 4; phase++) begin
      for (int n = 0; n < 600; n++) begin
        cyc($urandom_range(0, 9) < 7, pick_byte(), $urandom_range(0, 3) < phase + 1);
        if ($urandom_range(0, 999) == 0) do_reset();
      end
      drain();
    end

    check("drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
